// File: rtl/pe_host_seq_pkg.sv
// Shared types and constants for the PE host sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Holds the sequencer state enumeration, default matrix sizing and the
// word index where the vector/result region starts (N*N).
package pe_host_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_READ  = 3'd4,
    S_DRAIN = 3'd5
  } state_t;

  localparam int DEF_VECTOR_SIZE = 64;
  localparam int DEF_L_RAM_SIZE  = 6;

  // Vector words (and later the results) live right after the N*N matrix.
  localparam int RESULT_BASE = DEF_VECTOR_SIZE * DEF_VECTOR_SIZE;

  function automatic int result_base(input int n);
    return n * n;
  endfunction

endpackage

// File: rtl/pe_host_fifo2.sv
// Two-entry 32-bit FIFO buffering BRAM read results for the output stream.
// Latency: a pushed word is visible at o_dat the cycle after the push.
// Backpressure: pushes while full (without a pop) and pops while empty are dropped.
//
// Ports: i_clk/i_rst_n clock and async active-low reset; i_push/i_dat write side;
//        i_pop read side; o_dat head word; o_count occupancy 0..2; o_empty.
module pe_host_fifo2 (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_push,
  input  logic [31:0] i_dat,
  input  logic        i_pop,
  output logic [31:0] o_dat,
  output logic [1:0]  o_count,
  output logic        o_empty
);

  logic [31:0] r_mem [2];
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [1:0]  r_count;
  logic        w_do_push;
  logic        w_do_pop;

  assign w_do_pop  = i_pop && (r_count != 2'd0);
  assign w_do_push = i_push && ((r_count != 2'd2) || w_do_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_dat;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_do_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + 2'(w_do_push) - 2'(w_do_pop);
    end
  end

  assign o_dat   = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = (r_count == 2'd0);

endmodule

// File: rtl/pe_host_seq.sv
// Host-side job sequencer: streams matrix+vector into BRAM, kicks the PE, streams results out.
// Latency: first result m_valid 2 cycles after READ entry; 1 result/cycle with m_ready high.
// Backpressure: s_ready only in LOAD; result reads throttled so FIFO + in-flight never exceeds 2.
//
// Ports: aclk/aresetn; cmd_start job request; s_data/s_valid/s_ready load stream;
//        pe_start/pe_done PE handshake; bram_* single BRAM port (byte addresses);
//        m_data/m_valid/m_ready/m_last result stream; busy; timeout_err (sticky).
module pe_host_seq
  import pe_host_seq_pkg::*;
#(
  parameter int VECTOR_SIZE    = DEF_VECTOR_SIZE,
  parameter int L_RAM_SIZE     = DEF_L_RAM_SIZE,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        cmd_start,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        pe_start,
  input  logic        pe_done,
  output logic [31:0] bram_addr,
  output logic [31:0] bram_wrdata,
  output logic [3:0]  bram_we,
  output logic        bram_en,
  input  logic [31:0] bram_rddata,
  output logic [31:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last,
  output logic        busy,
  output logic        timeout_err
);

  localparam int          WCW       = 2 * L_RAM_SIZE + 2;
  localparam int          RIW       = L_RAM_SIZE + 1;
  localparam int          NUM_WORDS = VECTOR_SIZE * VECTOR_SIZE + VECTOR_SIZE;
  localparam int          RES_BASE  = result_base(VECTOR_SIZE);
  localparam logic [31:0] TO_LOAD   = 32'(TIMEOUT_CYCLES - 1);

  state_t         r_state;
  state_t         w_next;
  logic [WCW-1:0] r_wcnt;
  logic [RIW-1:0] r_rd_idx;
  logic [RIW-1:0] r_out_idx;
  logic [31:0]    r_tmo;
  logic           r_inflight;
  logic           r_timeout_err;
  logic           w_load_beat;
  logic           w_rd_issue;
  logic           w_pop;
  logic [1:0]     w_fifo_cnt;
  logic           w_fifo_empty;
  logic [2:0]     w_occ;

  assign m_valid     = !w_fifo_empty;
  assign w_pop       = m_valid && m_ready;
  assign m_last      = m_valid && (r_out_idx == RIW'(VECTOR_SIZE - 1));
  assign busy        = (r_state != S_IDLE);
  assign timeout_err = r_timeout_err;
  // A slot freed by this cycle's pop may be reused, which keeps 1 result/cycle flowing.
  assign w_occ       = 3'(w_fifo_cnt) + 3'(r_inflight) - 3'(w_pop);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    s_ready     = 1'b0;
    pe_start    = 1'b0;
    bram_en     = 1'b0;
    bram_we     = 4'h0;
    bram_addr   = 32'd0;
    bram_wrdata = 32'd0;
    w_load_beat = 1'b0;
    w_rd_issue  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_start) w_next = S_LOAD;
      end
      S_LOAD: begin
        s_ready = 1'b1;
        if (s_valid) begin
          w_load_beat = 1'b1;
          bram_en     = 1'b1;
          bram_we     = 4'hF;
          bram_addr   = 32'(r_wcnt) << 2;
          bram_wrdata = s_data;
          if (r_wcnt == WCW'(NUM_WORDS - 1)) w_next = S_START;
        end
      end
      S_START: begin
        pe_start = 1'b1;
        w_next   = S_WAIT;
      end
      S_WAIT: begin
        // pe_done takes priority over an expiring counter.
        if (pe_done) w_next = S_READ;
        else if (r_tmo == 32'd0) w_next = S_IDLE;
      end
      S_READ: begin
        if (w_occ < 3'd2) begin
          w_rd_issue = 1'b1;
          bram_en    = 1'b1;
          bram_addr  = (32'(RES_BASE) + 32'(r_rd_idx)) << 2;
          if (r_rd_idx == RIW'(VECTOR_SIZE - 1)) w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_pop && m_last) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wcnt        <= '0;
      r_rd_idx      <= '0;
      r_out_idx     <= '0;
      r_tmo         <= 32'd0;
      r_inflight    <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_inflight <= w_rd_issue;
      if (r_state == S_IDLE && cmd_start) begin
        r_wcnt        <= '0;
        r_rd_idx      <= '0;
        r_out_idx     <= '0;
        r_timeout_err <= 1'b0;
      end
      if (w_load_beat) r_wcnt <= r_wcnt + 1'b1;
      if (r_state == S_START) begin
        r_tmo <= TO_LOAD;
      end else if (r_state == S_WAIT && !pe_done) begin
        if (r_tmo == 32'd0) r_timeout_err <= 1'b1;
        else r_tmo <= r_tmo - 1'b1;
      end
      if (w_rd_issue) r_rd_idx <= r_rd_idx + 1'b1;
      if (w_pop) r_out_idx <= r_out_idx + 1'b1;
    end
  end

  // BRAM data returns one cycle after the read, so the FIFO push is the registered issue.
  pe_host_fifo2 u_fifo (
    .i_clk   (aclk),
    .i_rst_n (aresetn),
    .i_push  (r_inflight),
    .i_dat   (bram_rddata),
    .i_pop   (w_pop),
    .o_dat   (m_data),
    .o_count (w_fifo_cnt),
    .o_empty (w_fifo_empty)
  );

endmodule

// File: doc/pe_host_seq.md
PE_HOST_SEQ -- requirements
Module: pe_host_seq

Interface
REQ-001 Parameter VECTOR_SIZE, default 64: matrix dimension N and vector length.
REQ-002 Parameter L_RAM_SIZE, default 6: log2(VECTOR_SIZE).
REQ-003 Parameter TIMEOUT_CYCLES, default 1048576: maximum cycles to wait for pe_done.
REQ-004 The block SHALL have exactly one clock and an asynchronous, active-low reset, with ports aclk and aresetn.
REQ-005 aclk  in  1  sole clock; all state updates on rising edge.
REQ-006 aresetn  in  1  asynchronous active-low reset.
REQ-007 cmd_start  in  1  level request to begin one job; sampled in IDLE only.
REQ-008 s_data  in  32  load word (matrix row-major, then vector).
REQ-009 s_valid / s_ready  in / out  1 / 1  load stream handshake.
REQ-010 pe_start  out  1  one-cycle start pulse to the PE controller.
REQ-011 pe_done  in  1  completion pulse from the PE controller.
REQ-012 bram_addr  out  32  byte address, word index << 2.
REQ-013 bram_wrdata  out  32  write data.
REQ-014 bram_we  out  4  byte write enables; 4'hF or 0.
REQ-015 bram_en  out  1  port enable.
REQ-016 bram_rddata  in  32  read data, valid exactly 1 cycle after an enabled read.
REQ-017 m_data, m_valid, m_ready, m_last  out, out, in, out  32, 1, 1, 1  result stream.
REQ-018 busy  out  1  high in any state other than IDLE.
REQ-019 timeout_err  out  1  sticky flag, cleared on the next accepted cmd_start.

Function
REQ-020 States: IDLE, LOAD, START, WAIT, READ, DRAIN.
REQ-021 IDLE->LOAD when cmd_start=1; in any other state cmd_start SHALL be ignored.
REQ-022 LOAD: s_ready=1; each s_valid&s_ready beat k (0..N*N+N-1) SHALL write word index k the same cycle (bram_en=1, bram_we=4'hF); the word counter is L_RAM_SIZE*2+1 bits plus 1.
REQ-023 Beats 0..N*N-1 are matrix words (row-major); beats N*N..N*N+N-1 are vector words at word index N*N+i.
REQ-024 After beat N*N+N-1, s_ready SHALL drop the next cycle, and the state SHALL become START.
REQ-025 START: pe_start=1 for exactly one cycle, then WAIT; the timeout counter loads TIMEOUT_CYCLES-1.
REQ-026 WAIT: bram_en=0; pe_done=1 -> READ; counter reaching 0 without pe_done -> set timeout_err, go to IDLE.
REQ-027 pe_done and timeout expiry in the same cycle: pe_done wins, and timeout_err SHALL NOT be set.
REQ-028 READ: results are at word index N*N+i, i=0..N-1, which overwrites the vector region; issue read i (bram_en=1, bram_we=0) only when buffer occupancy plus in-flight reads is less than 2.
REQ-029 Returned data SHALL enter a 2-entry FIFO the cycle after issue; m_valid = FIFO not empty; pop on m_valid&m_ready.
REQ-030 m_last SHALL be 1 on result N-1 only.
REQ-031 After read N-1 is issued -> DRAIN; DRAIN->IDLE on the m_last handshake.
REQ-032 With m_ready held high, READ SHALL sustain 1 result per cycle; the first m_valid appears 2 cycles after READ entry.
REQ-033 m_data SHALL be stable while m_valid=1 and m_ready=0.
REQ-034 pe_done outside WAIT SHALL be ignored.

Reset
REQ-035 On aresetn=0, asynchronously: state=IDLE, all counters=0, FIFO empty, timeout_err=0, and every output=0.
REQ-036 Reset mid-job SHALL abort the job without a trailing pe_start, BRAM write, or m_valid after deassertion.

Structure
REQ-037 The shared package SHALL hold the state enumeration, the default VECTOR_SIZE/L_RAM_SIZE, and the result base index constant (N*N).
REQ-038 There SHALL be one sub-module, pe_host_fifo2: a 2-entry, 32-bit FIFO with count output.

Verification
REQ-039 Full job, N=4, ramp data 1..20, pe_done 10 cycles after pe_start, m_ready=1 -> 20 writes at byte addr 0..76, one pe_start, 4 reads at byte addr 64..76, m_last on the 4th.
REQ-040 s_valid toggled every other cycle -> exactly N*N+N writes, with no duplicate or skipped address.
REQ-041 m_ready low 5 cycles mid-stream -> no lost or duplicated results; at most 2 outstanding reads.
REQ-042 TIMEOUT_CYCLES=8, pe_done never asserted -> timeout_err=1 after 8 WAIT cycles, busy=0, no reads issued.
REQ-043 aresetn pulsed during LOAD beat 7 -> all outputs 0; the next job runs cleanly from index 0.
REQ-044 pe_done coincident with the final timeout cycle -> READ entered, timeout_err=0.
